// File: rtl/fetch_pipe.sv
// Multi-port instruction fetch stage: grant decode, per-port replicated I-cache,
// LAT-deep delivery pipeline with per-warp flush kill and sticky grant error flags.
module fetch_pipe #(
    parameter int NUM_WARPS = 8,
    parameter int NUM_PORTS = 2,
    parameter int PC_W      = 32,
    parameter int IMEM_AW   = 10,
    parameter int LAT       = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_WARPS*PC_W-1:0]       pc_flat,
    input  logic [NUM_PORTS*NUM_WARPS-1:0]  grant_flat,
    input  logic [NUM_WARPS-1:0]            pc_valid,
    input  logic [NUM_WARPS-1:0]            flush,
    input  logic                            fileio_wen,
    input  logic [IMEM_AW-1:0]              fileio_addr,
    input  logic [31:0]                     fileio_din,
    output logic [31:0]                     fileio_dout,
    output logic [NUM_PORTS*32-1:0]         instr_flat,
    output logic [NUM_PORTS*PC_W-1:0]       pc_plus4_flat,
    output logic [NUM_PORTS*NUM_WARPS-1:0]  valid_flat,
    output logic [NUM_WARPS-1:0]            inflight,
    output logic [NUM_PORTS-1:0]            grant_err
);

    logic [31:0]          mem     [NUM_PORTS][2**IMEM_AW];
    logic [NUM_WARPS-1:0] v_q     [NUM_PORTS][LAT];
    logic [PC_W-1:0]      pc4_q   [NUM_PORTS][LAT];
    logic [31:0]          instr_q [NUM_PORTS][LAT];

    logic [PC_W-1:0]      sel_pc   [NUM_PORTS];
    logic [IMEM_AW-1:0]   rd_addr  [NUM_PORTS];
    logic [NUM_WARPS-1:0] acc_mask [NUM_PORTS];
    logic                 acc      [NUM_PORTS];
    logic                 err_set  [NUM_PORTS];

    // Grant decode: lower-numbered ports claim a warp first; any grant bit on a
    // lower port (legal or not) blocks the same warp on higher ports.
    always_comb begin
        logic [NUM_WARPS-1:0] lower;
        logic [NUM_WARPS-1:0] g;
        logic [PC_W-1:0]      sp;
        logic                 onehot;
        logic                 dup;
        lower = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            g      = grant_flat[p*NUM_WARPS +: NUM_WARPS];
            onehot = (g != '0) && ((g & (g - 1'b1)) == '0);
            dup    = |(g & lower);
            sp     = '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (g[w]) sp = sp | pc_flat[w*PC_W +: PC_W];
            end
            acc[p]      = onehot && !dup && |(g & pc_valid & ~flush);
            err_set[p]  = ((g != '0) && !onehot) || (onehot && dup);
            acc_mask[p] = acc[p] ? g : '0;
            sel_pc[p]   = acc[p] ? sp : '0;
            rd_addr[p]  = sel_pc[p][IMEM_AW+1:2];
            lower       = lower | g;
        end
    end

    // I-cache copies: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (fileio_wen) begin
            for (int p = 0; p < NUM_PORTS; p++) mem[p][fileio_addr] <= fileio_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int k = 0; k < LAT; k++) begin
                    v_q[p][k]     <= '0;
                    pc4_q[p][k]   <= '0;
                    instr_q[p][k] <= '0;
                end
            end
            grant_err   <= '0;
            fileio_dout <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                // Read-first: the array read sees the pre-write word.
                v_q[p][0]     <= acc_mask[p];
                pc4_q[p][0]   <= acc[p] ? sel_pc[p] + PC_W'(4) : '0;
                instr_q[p][0] <= acc[p] ? mem[p][rd_addr[p]] : 32'h0;
                for (int k = 1; k < LAT; k++) begin
                    v_q[p][k]     <= v_q[p][k-1] & ~flush;
                    pc4_q[p][k]   <= pc4_q[p][k-1];
                    instr_q[p][k] <= instr_q[p][k-1];
                end
                grant_err[p] <= grant_err[p] | err_set[p];
            end
            fileio_dout <= mem[0][fileio_addr];
        end
    end

    always_comb begin
        instr_flat    = '0;
        pc_plus4_flat = '0;
        valid_flat    = '0;
        inflight      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            instr_flat[p*32 +: 32]                 = instr_q[p][LAT-1];
            pc_plus4_flat[p*PC_W +: PC_W]          = pc4_q[p][LAT-1];
            valid_flat[p*NUM_WARPS +: NUM_WARPS]   = v_q[p][LAT-1] & ~flush & pc_valid;
            for (int k = 0; k < LAT; k++) inflight = inflight | v_q[p][k];
        end
    end

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe with default parameters (8 warps, 2 ports, LAT=2).
module tb_fetch_pipe;

    logic         clk;
    logic         rst;
    logic [255:0] pc_flat;
    logic [15:0]  grant_flat;
    logic [7:0]   pc_valid;
    logic [7:0]   flush;
    logic         fileio_wen;
    logic [9:0]   fileio_addr;
    logic [31:0]  fileio_din;
    logic [31:0]  fileio_dout;
    logic [63:0]  instr_flat;
    logic [63:0]  pc_plus4_flat;
    logic [15:0]  valid_flat;
    logic [7:0]   inflight;
    logic [1:0]   grant_err;

    int errors = 0;
    int checks = 0;

    fetch_pipe dut (
        .clk(clk), .rst(rst), .pc_flat(pc_flat), .grant_flat(grant_flat),
        .pc_valid(pc_valid), .flush(flush), .fileio_wen(fileio_wen),
        .fileio_addr(fileio_addr), .fileio_din(fileio_din), .fileio_dout(fileio_dout),
        .instr_flat(instr_flat), .pc_plus4_flat(pc_plus4_flat), .valid_flat(valid_flat),
        .inflight(inflight), .grant_err(grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        fileio_wen  = 1'b1;
        fileio_addr = a;
        fileio_din  = d;
        tick();
        fileio_wen  = 1'b0;
    endtask

    task automatic set_pc(input int w, input logic [31:0] v);
        pc_flat[w*32 +: 32] = v;
    endtask

    initial begin
        rst = 1'b1; pc_flat = '0; grant_flat = '0; pc_valid = 8'hFF; flush = '0;
        fileio_wen = 1'b0; fileio_addr = '0; fileio_din = '0;
        set_pc(0, 32'h1C); set_pc(1, 32'h0);  set_pc(2, 32'h10); set_pc(3, 32'h14);
        set_pc(4, 32'h20); set_pc(5, 32'hFFFF_FFFC); set_pc(6, 32'h8); set_pc(7, 32'h0);
        tick(); tick();
        chk("rst_instr", instr_flat, 64'h0);
        chk("rst_pc4", pc_plus4_flat, 64'h0);
        chk("rst_valid", valid_flat, 16'h0);
        chk("rst_inflight", inflight, 8'h0);
        chk("rst_gerr", grant_err, 2'b00);
        chk("rst_dout", fileio_dout, 32'h0);
        rst = 1'b0;
        tick();

        load(10'd5, 32'hDEAD_BEEF); load(10'd0, 32'h1111_0000); load(10'd2, 32'h2222_0002);
        load(10'd4, 32'h4444_0004); load(10'd8, 32'h8888_0008); load(10'd7, 32'hAAAA_0007);
        load(10'h3FF, 32'h3FF3_FF00);

        // Single fetch, warp 3 on port 0
        grant_flat = 16'h0008; tick(); grant_flat = '0;
        chk("t1_inflight_t1", inflight, 8'h08);
        chk("t1_valid_t1", valid_flat, 16'h0);
        tick();
        chk("t1_instr", instr_flat[31:0], 32'hDEAD_BEEF);
        chk("t1_pc4", pc_plus4_flat[31:0], 32'h18);
        chk("t1_valid", valid_flat, 16'h0008);
        chk("t1_inflight_t2", inflight, 8'h08);
        tick();
        chk("t1_inflight_t3", inflight, 8'h00);
        chk("t1_valid_t3", valid_flat, 16'h0);
        tick();

        // Two ports in the same cycle
        grant_flat = 16'h4002; tick(); grant_flat = '0; tick();
        chk("t2_instr", instr_flat, 64'h2222_0002_1111_0000);
        chk("t2_pc4", pc_plus4_flat, 64'h0000_000C_0000_0004);
        chk("t2_valid", valid_flat, 16'h4002);
        chk("t2_inflight", inflight, 8'h42);
        tick(); tick();

        // Flush kills an in-flight fetch; instr is left stale
        grant_flat = 16'h0004; tick(); grant_flat = '0;
        flush = 8'h04; #1;
        chk("t3_valid_t1", valid_flat, 16'h0);
        chk("t3_inflight_t1", inflight, 8'h04);
        tick(); flush = '0; #1;
        chk("t3_valid_t2", valid_flat, 16'h0);
        chk("t3_inflight_t2", inflight, 8'h00);
        chk("t3_instr_stale", instr_flat[31:0], 32'h4444_0004);
        tick(); tick();

        // Combinational masking of the output by flush and pc_valid
        grant_flat = 16'h0008; tick(); grant_flat = '0; tick();
        chk("t4_valid", valid_flat, 16'h0008);
        flush = 8'h08; #1;
        chk("t4_flush_mask", valid_flat, 16'h0);
        flush = 8'h00; #1;
        chk("t4_unmask", valid_flat, 16'h0008);
        pc_valid = 8'hF7; #1;
        chk("t4_pcv_mask", valid_flat, 16'h0);
        pc_valid = 8'hFF;
        tick(); tick();

        // Non-one-hot grant
        grant_flat = 16'h0003; tick(); grant_flat = '0;
        chk("t5_gerr", grant_err, 2'b01);
        tick();
        chk("t5_nofetch", valid_flat, 16'h0);
        tick();
        chk("t5_gerr_held", grant_err, 2'b01);

        // Duplicate warp across ports
        grant_flat = 16'h1010; tick(); grant_flat = '0; tick();
        chk("t6_valid", valid_flat, 16'h0010);
        chk("t6_pc4", pc_plus4_flat, 64'h0000_0000_0000_0024);
        chk("t6_instr0", instr_flat[31:0], 32'h8888_0008);
        chk("t6_gerr", grant_err, 2'b11);
        tick(); tick();

        // Inactive warp: no fetch, no error
        pc_valid = 8'hEF; grant_flat = 16'h0010; tick(); grant_flat = '0;
        chk("t7_inflight", inflight, 8'h00);
        pc_valid = 8'hFF; tick();
        chk("t7_valid", valid_flat, 16'h0);
        chk("t7_gerr", grant_err, 2'b11);
        tick();

        // PC wrap on port 1
        grant_flat = 16'h2000; tick(); grant_flat = '0; tick();
        chk("t8_pc4_wrap", pc_plus4_flat[63:32], 32'h0);
        chk("t8_instr1", instr_flat[63:32], 32'h3FF3_FF00);
        chk("t8_valid", valid_flat, 16'h2000);
        tick(); tick();

        // Read-first on a same-address write, then the new word
        grant_flat = 16'h0001; fileio_wen = 1'b1; fileio_addr = 10'd7; fileio_din = 32'h0000_1234;
        tick(); grant_flat = '0; fileio_wen = 1'b0; tick();
        chk("t9_read_first", instr_flat[31:0], 32'hAAAA_0007);
        grant_flat = 16'h0001; tick(); grant_flat = '0; tick();
        chk("t9_new_word", instr_flat[31:0], 32'h0000_1234);
        fileio_addr = 10'd5; tick();
        chk("t9_dout5", fileio_dout, 32'hDEAD_BEEF);
        fileio_addr = 10'd7; tick();
        chk("t9_dout7", fileio_dout, 32'h0000_1234);

        // Asynchronous reset in the middle of a fetch
        grant_flat = 16'h4002; tick(); grant_flat = '0; tick();
        chk("t10_pre_valid", valid_flat, 16'h4002);
        #2 rst = 1'b1; #1;
        chk("t10_valid", valid_flat, 16'h0);
        chk("t10_instr", instr_flat, 64'h0);
        chk("t10_pc4", pc_plus4_flat, 64'h0);
        chk("t10_inflight", inflight, 8'h0);
        chk("t10_gerr", grant_err, 2'b00);
        chk("t10_dout", fileio_dout, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
